// File: rtl/switch_allocator_if.sv
// Allocator-facing bundle: request matrix, tails and credit returns in; acks, crossbar selects and credit levels out.
// credit_err exists only when SWITCH_ALLOC_CREDIT_CHECK_EN is defined.
interface switch_allocator_if #(
   parameter int PORTS   = 5,
   parameter int CREDITS = 4
);
   localparam int CNT_W = $clog2(CREDITS + 1);

   logic [PORTS*PORTS-1:0] port_rqs;
   logic [PORTS-1:0]       flit_tail;
   logic [PORTS-1:0]       credit_in;
   logic [PORTS-1:0]       arb_ack;
   logic [PORTS*PORTS-1:0] xbar_cfg_vector;
   logic [PORTS*CNT_W-1:0] credit_cnt;
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
   logic [PORTS-1:0]       credit_err;
`endif

   modport master (
      output port_rqs, flit_tail, credit_in,
      input  arb_ack, xbar_cfg_vector, credit_cnt
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
      , input credit_err
`endif
   );

   modport slave (
      input  port_rqs, flit_tail, credit_in,
      output arb_ack, xbar_cfg_vector, credit_cnt
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
      , output credit_err
`endif
   );
endinterface

// File: rtl/switch_allocator.sv
// Round-robin, wormhole-locking, credit-gated switch allocator; grant 1 cycle after request, acks stall at 0 credits.
// Optional sticky credit_err per outport under SWITCH_ALLOC_CREDIT_CHECK_EN.
module switch_allocator #(
   parameter int PORTS   = 5,
   parameter int CREDITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   switch_allocator_if.slave sa
);
   localparam int CNT_W = $clog2(CREDITS + 1);
   localparam int IDX_W = $clog2(PORTS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

   typedef enum logic {IDLE, LOCKED} st_t;

   st_t              st_q    [PORTS];
   logic [IDX_W-1:0] owner_q [PORTS];
   logic [IDX_W-1:0] rr_q    [PORTS];
   logic [CNT_W-1:0] cnt_q   [PORTS];
   logic [PORTS-1:0] cfg_q   [PORTS];
   logic [CNT_W-1:0] cnt_d   [PORTS];
   logic [IDX_W-1:0] rr_d    [PORTS];
   logic [IDX_W-1:0] grant_idx [PORTS];
   logic [PORTS-1:0] req_dec [PORTS];
   logic [PORTS-1:0] held;
   logic [PORTS-1:0] xfer;
   logic [PORTS-1:0] tail_xfer;
   logic [PORTS-1:0] grant_vld;
   logic [PORTS-1:0] ack;
   int               idx;

   always_comb begin
      held      = '0;
      ack       = '0;
      xfer      = '0;
      tail_xfer = '0;
      grant_vld = '0;
      idx       = 0;
      // lowest set bit wins, so each inport targets at most one outport
      for (int i = 0; i < PORTS; i++) begin
         req_dec[i] = sa.port_rqs[i*PORTS +: PORTS] & (~sa.port_rqs[i*PORTS +: PORTS] + 1'b1);
      end
      for (int j = 0; j < PORTS; j++) begin
         held = held | cfg_q[j];
      end
      for (int j = 0; j < PORTS; j++) begin
         grant_idx[j] = '0;
         xfer[j]      = (st_q[j] == LOCKED) && req_dec[owner_q[j]][j] && (cnt_q[j] != '0);
         tail_xfer[j] = xfer[j] && sa.flit_tail[owner_q[j]];
         if (xfer[j]) begin
            ack = ack | cfg_q[j];
         end
         rr_d[j] = (int'(owner_q[j]) == PORTS - 1) ? '0 : owner_q[j] + 1'b1;

         if (st_q[j] == IDLE && cnt_q[j] != '0) begin
            for (int k = 0; k < PORTS; k++) begin
               idx = int'(rr_q[j]) + k;
               if (idx >= PORTS) begin
                  idx = idx - PORTS;
               end
               if (!grant_vld[j] && req_dec[idx][j] && !held[idx]) begin
                  grant_vld[j] = 1'b1;
                  grant_idx[j] = IDX_W'(idx);
               end
            end
         end

         cnt_d[j] = cnt_q[j];
         if (xfer[j] && !sa.credit_in[j]) begin
            cnt_d[j] = cnt_q[j] - 1'b1;
         end else if (!xfer[j] && sa.credit_in[j] && cnt_q[j] != CNT_MAX) begin
            cnt_d[j] = cnt_q[j] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < PORTS; j++) begin
            st_q[j]    <= IDLE;
            owner_q[j] <= '0;
            rr_q[j]    <= '0;
            cnt_q[j]   <= CNT_MAX;
            cfg_q[j]   <= '0;
         end
      end else begin
         for (int j = 0; j < PORTS; j++) begin
            cnt_q[j] <= cnt_d[j];
            case (st_q[j])
               IDLE: begin
                  if (grant_vld[j]) begin
                     st_q[j]    <= LOCKED;
                     owner_q[j] <= grant_idx[j];
                     cfg_q[j]   <= PORTS'(1) << grant_idx[j];
                  end
               end
               LOCKED: begin
                  if (tail_xfer[j]) begin
                     st_q[j]  <= IDLE;
                     cfg_q[j] <= '0;
                     rr_q[j]  <= rr_d[j];
                  end
               end
               default: begin
                  st_q[j]  <= IDLE;
                  cfg_q[j] <= '0;
               end
            endcase
         end
      end
   end

`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
   logic [PORTS-1:0] err_q;

   // overflow: a return with no slot outstanding; underflow guards the ack gating
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= '0;
      end else begin
         for (int j = 0; j < PORTS; j++) begin
            if ((sa.credit_in[j] && !xfer[j] && cnt_q[j] == CNT_MAX) ||
                (xfer[j] && cnt_q[j] == '0)) begin
               err_q[j] <= 1'b1;
            end
         end
      end
   end

   assign sa.credit_err = err_q;
`endif

   always_comb begin
      sa.arb_ack = ack;
      for (int j = 0; j < PORTS; j++) begin
         sa.xbar_cfg_vector[j*PORTS +: PORTS] = cfg_q[j];
         sa.credit_cnt[j*CNT_W +: CNT_W]      = cnt_q[j];
      end
   end
endmodule

// File: tb/tb_switch_allocator.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model of the allocator.
module tb_switch_allocator;
   localparam int P  = 5;
   localparam int C  = 4;
   localparam int CW = $clog2(C + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   switch_allocator_if #(.PORTS(P), .CREDITS(C)) sa_if ();
   switch_allocator #(.PORTS(P), .CREDITS(C)) dut (.clk(clk), .rst(rst), .sa(sa_if.slave));

   int n_checks = 0;
   int n_errors = 0;

   // model: owner per outport (-1 = idle), round-robin start, credits, sticky error
   int          m_own [P];
   int          m_rr  [P];
   int          m_cr  [P];
   logic [P-1:0] m_err;
   logic [P*CW-1:0] cnt_full;
   logic [P-1:0] exp_ack_tbl [8] = '{5'b00000, 5'b00010, 5'b00000, 5'b01000,
                                     5'b00000, 5'b10000, 5'b00000, 5'b00010};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int dest_of(input int i);
      logic [P-1:0] v;
      v = sa_if.port_rqs[i*P +: P];
      for (int j = 0; j < P; j++) if (v[j]) return j;
      return -1;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < P; j++) begin
         m_own[j] = -1;
         m_rr[j]  = 0;
         m_cr[j]  = C;
      end
      m_err = '0;
   endtask

   task automatic model_check();
      logic [P-1:0]    e_ack;
      logic [P*P-1:0]  e_cfg;
      logic [P*CW-1:0] e_cnt;
      e_ack = '0;
      e_cfg = '0;
      e_cnt = '0;
      for (int j = 0; j < P; j++) begin
         if (m_own[j] >= 0) begin
            e_cfg[j*P + m_own[j]] = 1'b1;
            if (dest_of(m_own[j]) == j && m_cr[j] > 0) e_ack[m_own[j]] = 1'b1;
         end
         e_cnt[j*CW +: CW] = CW'(m_cr[j]);
      end
      check_eq("arb_ack", 32'(sa_if.arb_ack), 32'(e_ack));
      check_eq("xbar_cfg", 32'(sa_if.xbar_cfg_vector), 32'(e_cfg));
      check_eq("credit_cnt", 32'(sa_if.credit_cnt), 32'(e_cnt));
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
      check_eq("credit_err", 32'(sa_if.credit_err), 32'(m_err));
`endif
   endtask

   task automatic model_update();
      bit busy [P];
      int xf, cin, own, old_cr;
      if (!rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < P; i++) busy[i] = 1'b0;
      for (int j = 0; j < P; j++) if (m_own[j] >= 0) busy[m_own[j]] = 1'b1;
      for (int j = 0; j < P; j++) begin
         own    = m_own[j];
         old_cr = m_cr[j];
         xf     = (own >= 0 && dest_of(own) == j && old_cr > 0) ? 1 : 0;
         cin    = int'(sa_if.credit_in[j]);
         if ((cin == 1 && xf == 0 && old_cr == C) || (xf == 1 && old_cr == 0)) m_err[j] = 1'b1;
         m_cr[j] = old_cr - xf + cin;
         if (m_cr[j] > C) m_cr[j] = C;
         if (own >= 0) begin
            if (xf == 1 && sa_if.flit_tail[own]) begin
               m_rr[j]  = (own + 1) % P;
               m_own[j] = -1;
            end
         end else if (old_cr > 0) begin
            for (int k = 0; k < P; k++) begin
               int i;
               i = (m_rr[j] + k) % P;
               if (m_own[j] < 0 && dest_of(i) == j && !busy[i]) m_own[j] = i;
            end
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      sa_if.port_rqs  = '0;
      sa_if.flit_tail = '0;
      sa_if.credit_in = '0;
   endtask

   task automatic set_req(input int i, input logic [P-1:0] v, input logic tail);
      sa_if.port_rqs[i*P +: P] = v;
      sa_if.flit_tail[i]       = tail;
   endtask

   initial begin
      for (int j = 0; j < P; j++) cnt_full[j*CW +: CW] = CW'(C);
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      model_reset();
      #1 rst = 1'b1;

      // reset state, then single-flit 0 -> 2
      set_req(0, 5'b00100, 1'b1);
      settle();
      check_eq("rst_cnt", 32'(sa_if.credit_cnt), 32'(cnt_full));
      check_eq("rst_cfg", 32'(sa_if.xbar_cfg_vector), 32'd0);
      check_eq("rst_ack", 32'(sa_if.arb_ack), 32'd0);
      advance();
      settle();
      check_eq("single_ack", 32'(sa_if.arb_ack), 32'b00001);
      check_eq("single_cfg2", 32'(sa_if.xbar_cfg_vector[2*P +: P]), 32'b00001);
      advance();
      clear_inputs();
      settle();
      check_eq("single_cnt2", 32'(sa_if.credit_cnt[2*CW +: CW]), 32'd3);
      advance();

      // contention on outport 0, credits topped up continuously
      set_req(1, 5'b00001, 1'b1);
      set_req(3, 5'b00001, 1'b1);
      set_req(4, 5'b00001, 1'b1);
      sa_if.credit_in = 5'b00001;
      for (int c = 0; c < 8; c++) begin
         settle();
         check_eq("rr_ack", 32'(sa_if.arb_ack), 32'(exp_ack_tbl[c]));
         advance();
      end
      clear_inputs();
      settle();
      advance();

      // wormhole lock: inport 2 three flits to outport 4, inport 0 waits
      set_req(2, 5'b10000, 1'b0);
      settle();
      advance();
      set_req(0, 5'b10000, 1'b1);
      for (int c = 0; c < 3; c++) begin
         if (c == 2) sa_if.flit_tail[2] = 1'b1;
         settle();
         check_eq("worm_ack", 32'(sa_if.arb_ack), 32'b00100);
         advance();
      end
      set_req(2, 5'b00000, 1'b0);
      settle();
      check_eq("worm_bubble", 32'(sa_if.arb_ack), 32'd0);
      advance();
      settle();
      check_eq("worm_next", 32'(sa_if.arb_ack), 32'b00001);
      advance();
      clear_inputs();

      // credit starvation on outport 1
      set_req(1, 5'b00010, 1'b0);
      settle();
      advance();
      for (int c = 0; c < 4; c++) begin
         settle();
         check_eq("starve_ack", 32'(sa_if.arb_ack), 32'b00010);
         advance();
      end
      settle();
      check_eq("starve_stall", 32'(sa_if.arb_ack), 32'd0);
      check_eq("starve_cnt0", 32'(sa_if.credit_cnt[1*CW +: CW]), 32'd0);
      sa_if.credit_in[1] = 1'b1;
      advance();
      sa_if.credit_in[1] = 1'b0;
      settle();
      check_eq("starve_one", 32'(sa_if.arb_ack), 32'b00010);
      advance();
      settle();
      check_eq("starve_again", 32'(sa_if.arb_ack), 32'd0);
      set_req(1, 5'b00000, 1'b0);
      sa_if.credit_in[1] = 1'b1;
      advance();
      settle();
      check_eq("hold_lock", 32'(sa_if.xbar_cfg_vector[1*P +: P]), 32'b00010);
      advance();
      set_req(1, 5'b00010, 1'b1);
      settle();
      check_eq("coinc_ack", 32'(sa_if.arb_ack), 32'b00010);
      check_eq("coinc_pre", 32'(sa_if.credit_cnt[1*CW +: CW]), 32'd2);
      advance();
      clear_inputs();
      settle();
      check_eq("coinc_cnt", 32'(sa_if.credit_cnt[1*CW +: CW]), 32'd2);
      advance();

      // non-one-hot request from inport 3
      set_req(3, 5'b10100, 1'b1);
      settle();
      advance();
      settle();
      check_eq("nonhot_ack", 32'(sa_if.arb_ack), 32'b01000);
      check_eq("nonhot_cfg2", 32'(sa_if.xbar_cfg_vector[2*P +: P]), 32'b01000);
      check_eq("nonhot_cfg4", 32'(sa_if.xbar_cfg_vector[4*P +: P]), 32'd0);
      advance();
      clear_inputs();

      // reset during flit 2 of a 4-flit packet
      set_req(4, 5'b01000, 1'b0);
      settle();
      advance();
      settle();
      advance();
      rst = 1'b0;
      settle();
      check_eq("mid_ack", 32'(sa_if.arb_ack), 32'b10000);
      advance();
      rst = 1'b1;
      clear_inputs();
      settle();
      check_eq("mid_cfg", 32'(sa_if.xbar_cfg_vector), 32'd0);
      check_eq("mid_ack0", 32'(sa_if.arb_ack), 32'd0);
      check_eq("mid_cnt", 32'(sa_if.credit_cnt), 32'(cnt_full));
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
      check_eq("err_clr", 32'(sa_if.credit_err), 32'd0);
      sa_if.credit_in[0] = 1'b1;
      advance();
      sa_if.credit_in[0] = 1'b0;
      settle();
      check_eq("err_set", 32'(sa_if.credit_err), 32'b00001);
      advance();
      settle();
      check_eq("err_sticky", 32'(sa_if.credit_err), 32'b00001);
`endif
      advance();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < P; i++) begin
            logic [P-1:0] v;
            case ($urandom_range(0, 9))
               0, 1, 2: v = '0;
               3:       v = P'($urandom_range(1, (1 << P) - 1));
               default: v = P'(1) << $urandom_range(0, P - 1);
            endcase
            set_req(i, v, ($urandom_range(0, 2) == 0));
            sa_if.credit_in[i] = ($urandom_range(0, 3) == 0);
         end
         rst = ($urandom_range(0, 199) != 0);
         settle();
         advance();
      end
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
